brq_timer_irq: RTL and testbench

Memory-mapped machine timer (mtime/mtimecmp/msip) that acts as a responder on the core's req/gnt/rvalid data-bus interface. It is the producing end of the irq_timer and irq_software lines of the core's irqs_t interrupt bundle. It sits on the data interconnect next to RAM. The interconnect performs the base-address decode; this block decodes only the low offset bits.

---
 rtl/brq_timer_irq.sv | 114 +++++++++++
 tb/tb_brq_timer_irq.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/brq_timer_irq.sv
// Memory-mapped machine timer (mtime/mtimecmp/msip) on the req/gnt/rvalid data bus.
// Optional prescaler enabled with `define BRQ_TIMER_PRESCALER_EN.
module brq_timer_irq #(
  parameter int                      PrescaleWidth   = 16,
  parameter logic [PrescaleWidth-1:0] PrescaleDefault = '0
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        data_req_i,
  output logic        data_gnt_o,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o,
  output logic        data_err_o,
  output logic        irq_timer_o,
  output logic        irq_software_o
);

  localparam logic [2:0] REG_MTIME_LO    = 3'd0;
  localparam logic [2:0] REG_MTIME_HI    = 3'd1;
  localparam logic [2:0] REG_MTIMECMP_LO = 3'd2;
  localparam logic [2:0] REG_MTIMECMP_HI = 3'd3;
  localparam logic [2:0] REG_MSIP        = 3'd4;
  localparam logic [2:0] REG_PRESCALE    = 3'd5;

  logic [63:0] mtime, mtimecmp;
  logic        msip;
  logic        tick;
  logic [2:0]  idx;
  logic        mapped, err, wr_en, rd_en;
  logic [31:0] rd_val;

  // Base decode happens in the interconnect; upper address bits are don't-care here.
  logic unused_addr;
  assign unused_addr = ^data_addr_i[31:5];

  assign data_gnt_o = data_req_i;
  assign idx        = data_addr_i[4:2];

`ifdef BRQ_TIMER_PRESCALER_EN
  logic [PrescaleWidth-1:0] prescale, tick_cnt;
  assign tick = (tick_cnt == prescale);
`else
  logic [PrescaleWidth-1:0] unused_prescale;
  assign unused_prescale = PrescaleDefault;
  assign tick = 1'b1;
`endif

  always_comb begin
    mapped = 1'b0;
    rd_val = '0;
    case (idx)
      REG_MTIME_LO:    begin mapped = 1'b1; rd_val = mtime[31:0];     end
      REG_MTIME_HI:    begin mapped = 1'b1; rd_val = mtime[63:32];    end
      REG_MTIMECMP_LO: begin mapped = 1'b1; rd_val = mtimecmp[31:0];  end
      REG_MTIMECMP_HI: begin mapped = 1'b1; rd_val = mtimecmp[63:32]; end
      REG_MSIP:        begin mapped = 1'b1; rd_val = {31'd0, msip};   end
`ifdef BRQ_TIMER_PRESCALER_EN
      REG_PRESCALE:    begin mapped = 1'b1; rd_val = 32'(prescale);   end
`endif
      default:         begin mapped = 1'b0; rd_val = '0;              end
    endcase
  end

  assign err   = (data_addr_i[1:0] != 2'b00) | ~mapped | (data_we_i & (data_be_i != 4'hF));
  assign wr_en = data_req_i & data_we_i & ~err;
  assign rd_en = data_req_i & ~data_we_i & ~err;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_rvalid_o  <= 1'b0;
      data_rdata_o   <= '0;
      data_err_o     <= 1'b0;
      irq_timer_o    <= 1'b0;
      irq_software_o <= 1'b0;
      mtime          <= '0;
      mtimecmp       <= '1;
      msip           <= 1'b0;
    end else begin
      data_rvalid_o  <= data_req_i;
      data_err_o     <= data_req_i & err;
      data_rdata_o   <= rd_en ? rd_val : '0;
      irq_timer_o    <= (mtime >= mtimecmp);
      irq_software_o <= msip;
      // A write to either mtime half discards that cycle's increment entirely.
      if (wr_en && idx == REG_MTIME_LO)      mtime[31:0]  <= data_wdata_i;
      else if (wr_en && idx == REG_MTIME_HI) mtime[63:32] <= data_wdata_i;
      else if (tick)                         mtime        <= mtime + 64'd1;
      if (wr_en && idx == REG_MTIMECMP_LO) mtimecmp[31:0]  <= data_wdata_i;
      if (wr_en && idx == REG_MTIMECMP_HI) mtimecmp[63:32] <= data_wdata_i;
      if (wr_en && idx == REG_MSIP)        msip            <= data_wdata_i[0];
    end
  end

`ifdef BRQ_TIMER_PRESCALER_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prescale <= PrescaleDefault;
      tick_cnt <= '0;
    end else if (wr_en && idx == REG_PRESCALE) begin
      prescale <= data_wdata_i[PrescaleWidth-1:0];
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_brq_timer_irq.sv
// Directed bench for brq_timer_irq: vector table for register access plus
// hand sequences for counting, interrupts, wrap and reset.
module tb_brq_timer_irq;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        data_req_i, data_gnt_o, data_we_i;
  logic [3:0]  data_be_i;
  logic [31:0] data_addr_i, data_wdata_i, data_rdata_o;
  logic        data_rvalid_o, data_err_o, irq_timer_o, irq_software_o;

  int checks = 0;
  int failures = 0;

  brq_timer_irq dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .data_req_i(data_req_i), .data_gnt_o(data_gnt_o), .data_we_i(data_we_i),
    .data_be_i(data_be_i), .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i),
    .data_rvalid_o(data_rvalid_o), .data_rdata_o(data_rdata_o), .data_err_o(data_err_o),
    .irq_timer_o(irq_timer_o), .irq_software_o(irq_software_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    string       name;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_err;
    logic        chk_rd;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Called at a negedge; grant on the next posedge, response sampled #1 later; returns at a negedge.
  task automatic bus(input logic we, input logic [3:0] be, input logic [31:0] addr,
                     input logic [31:0] wdata, output logic [31:0] rd, output logic er);
    data_req_i = 1'b1; data_we_i = we; data_be_i = be; data_addr_i = addr; data_wdata_i = wdata;
    #1 chk("gnt", {31'd0, data_gnt_o}, 32'd1);
    @(posedge clk_i); #1;
    chk("rvalid", {31'd0, data_rvalid_o}, 32'd1);
    rd = data_rdata_o;
    er = data_err_o;
    data_req_i = 1'b0; data_we_i = 1'b0;
    @(negedge clk_i);
  endtask

  task automatic rd_chk(input string name, input logic [31:0] addr, input logic [31:0] exp);
    logic [31:0] rd; logic er;
    bus(1'b0, 4'hF, addr, 32'd0, rd, er);
    chk({name, "_err"}, {31'd0, er}, 32'd0);
    chk(name, rd, exp);
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] wdata);
    logic [31:0] rd; logic er;
    bus(1'b1, 4'hF, addr, wdata, rd, er);
    chk("wr_err", {31'd0, er}, 32'd0);
  endtask

  initial begin
    logic [31:0] rd;
    logic er;

    tbl.push_back('{"cmplo_wr",     1, 4'hF, 32'h08, 32'h1234_5678, 0, 0, 32'h0});
    tbl.push_back('{"cmplo_rd",     0, 4'hF, 32'h08, 32'h0,         0, 1, 32'h1234_5678});
    tbl.push_back('{"cmplo_wr_be3", 1, 4'h3, 32'h08, 32'h0000_DEAD, 1, 0, 32'h0});
    tbl.push_back('{"cmplo_keep",   0, 4'h0, 32'h08, 32'h0,         0, 1, 32'h1234_5678});
    tbl.push_back('{"cmphi_rst",    0, 4'hF, 32'h0C, 32'h0,         0, 1, 32'hFFFF_FFFF});
    tbl.push_back('{"cmphi_wr",     1, 4'hF, 32'h0C, 32'hA5A5_0001, 0, 0, 32'h0});
    tbl.push_back('{"cmphi_rd",     0, 4'hF, 32'h0C, 32'h0,         0, 1, 32'hA5A5_0001});
    tbl.push_back('{"rd_misal",     0, 4'hF, 32'h02, 32'h0,         1, 1, 32'h0});
    tbl.push_back('{"wr_misal",     1, 4'hF, 32'h0E, 32'h5555_5555, 1, 0, 32'h0});
    tbl.push_back('{"cmphi_keep",   0, 4'hF, 32'h0C, 32'h0,         0, 1, 32'hA5A5_0001});
    tbl.push_back('{"rd_0x18",      0, 4'hF, 32'h18, 32'h0,         1, 1, 32'h0});
    tbl.push_back('{"rd_0x1c",      0, 4'hF, 32'h1C, 32'h0,         1, 1, 32'h0});
    tbl.push_back('{"wr_0x1c",      1, 4'hF, 32'h1C, 32'h1,         1, 0, 32'h0});
    tbl.push_back('{"msip_rd0",     0, 4'hF, 32'h10, 32'h0,         0, 1, 32'h0});
`ifdef BRQ_TIMER_PRESCALER_EN
    tbl.push_back('{"presc_rst",    0, 4'hF, 32'h14, 32'h0,         0, 1, 32'h0});
`else
    tbl.push_back('{"rd_0x14",      0, 4'hF, 32'h14, 32'h0,         1, 1, 32'h0});
    tbl.push_back('{"wr_0x14",      1, 4'hF, 32'h14, 32'h3,         1, 0, 32'h0});
`endif

    rst_ni = 1'b0; data_req_i = 1'b0; data_we_i = 1'b0; data_be_i = 4'h0;
    data_addr_i = '0; data_wdata_i = '0;
    repeat (3) @(negedge clk_i);
    chk("rst_rvalid", {31'd0, data_rvalid_o}, 32'd0);
    chk("rst_rdata", data_rdata_o, 32'd0);
    chk("rst_err", {31'd0, data_err_o}, 32'd0);
    chk("rst_irq_t", {31'd0, irq_timer_o}, 32'd0);
    chk("rst_irq_s", {31'd0, irq_software_o}, 32'd0);
    chk("gnt_idle", {31'd0, data_gnt_o}, 32'd0);
    rst_ni = 1'b1;

    // First grant lands on the first edge after reset release: mtime is 0, then 1.
    rd_chk("mtime_c0", 32'h00, 32'd0);
    rd_chk("mtime_c1", 32'h00, 32'd1);

    foreach (tbl[i]) begin
      bus(tbl[i].we, tbl[i].be, tbl[i].addr, tbl[i].wdata, rd, er);
      chk({tbl[i].name, "_err"}, {31'd0, er}, {31'd0, tbl[i].exp_err});
      if (tbl[i].chk_rd) chk(tbl[i].name, rd, tbl[i].exp_rd);
    end

    // Isolated cycle after a response: rvalid and rdata return to 0.
    @(posedge clk_i); #1;
    chk("rvalid_drop", {31'd0, data_rvalid_o}, 32'd0);
    chk("rdata_idle", data_rdata_o, 32'd0);
    @(negedge clk_i);

    // Software interrupt.
    wr(32'h10, 32'h3);
    @(posedge clk_i); #1;
    chk("irq_sw_set", {31'd0, irq_software_o}, 32'd1);
    @(negedge clk_i);
    rd_chk("msip_rd1", 32'h10, 32'd1);
    wr(32'h10, 32'h0);
    @(posedge clk_i); #1;
    chk("irq_sw_clr", {31'd0, irq_software_o}, 32'd0);
    @(negedge clk_i);

    // Timer interrupt: mtime=0 after write edge, k after k more edges; irq follows one edge later.
    wr(32'h0C, 32'h0);
    wr(32'h08, 32'd40);
    wr(32'h04, 32'h0);
    wr(32'h00, 32'h0);
    for (int i = 1; i <= 41; i++) begin
      @(posedge clk_i); #1;
      if (i == 40) chk("irq_t_pre", {31'd0, irq_timer_o}, 32'd0);
      if (i == 41) chk("irq_t_rise", {31'd0, irq_timer_o}, 32'd1);
    end
    @(negedge clk_i);
    wr(32'h08, 32'd1000);
    chk("irq_t_hold", {31'd0, irq_timer_o}, 32'd1);
    @(posedge clk_i); #1;
    chk("irq_t_fall", {31'd0, irq_timer_o}, 32'd0);
    @(negedge clk_i);

    // Carry from LO into HI.
    wr(32'h04, 32'h0);
    wr(32'h00, 32'hFFFF_FFFE);
    rd_chk("wrap_lo_fe", 32'h00, 32'hFFFF_FFFE);
    rd_chk("wrap_hi_0", 32'h04, 32'h0);
    rd_chk("wrap_lo_0", 32'h00, 32'h0);
    rd_chk("wrap_hi_1", 32'h04, 32'h1);

    // HI write during a carrying tick: LO keeps its value, no carry.
    wr(32'h00, 32'hFFFF_FFFF);
    wr(32'h04, 32'h5);
    rd_chk("wwin_lo", 32'h00, 32'hFFFF_FFFF);
    rd_chk("wwin_hi", 32'h04, 32'h6);

`ifdef BRQ_TIMER_PRESCALER_EN
    // PRESCALE=3: one tick every 4 cycles starting from a cleared counter.
    wr(32'h14, 32'd3);
    wr(32'h00, 32'h0);
    repeat (2) @(negedge clk_i);
    rd_chk("presc_t0", 32'h00, 32'd0);
    rd_chk("presc_t1", 32'h00, 32'd1);
    repeat (3) @(negedge clk_i);
    rd_chk("presc_t2", 32'h00, 32'd2);
    rd_chk("presc_rd3", 32'h14, 32'd3);
`endif

    // Reset during a pending read: no rvalid, state back to reset values.
    wr(32'h10, 32'h1);
    data_req_i = 1'b1; data_we_i = 1'b0; data_addr_i = 32'h0C;
    #2 rst_ni = 1'b0;
    @(posedge clk_i); #1;
    chk("rst_mid_rvalid", {31'd0, data_rvalid_o}, 32'd0);
    data_req_i = 1'b0;
    @(negedge clk_i);
    chk("rst_mid_irq_s", {31'd0, irq_software_o}, 32'd0);
    rst_ni = 1'b1;
    rd_chk("rst_cmphi", 32'h0C, 32'hFFFF_FFFF);
    rd_chk("rst_msip", 32'h10, 32'd0);
    rd_chk("rst_mtime", 32'h00, 32'd2);
`ifdef BRQ_TIMER_PRESCALER_EN
    rd_chk("rst_presc", 32'h14, 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
